router_lpm_searcher: RTL and testbench

Longest-prefix-match successor to the exact-match route searcher in the forwarding path. It holds a parametrised table of 256-bit route entries, each with a prefix length. It answers tagged lookups through a 3-stage pipeline with valid/ready handshakes on both sides, and it accepts runtime table updates without an init mode. It sits between the packet header parser (lookup side) and the egress scheduler (response side).

---
 rtl/router_lpm_searcher.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_router_lpm_searcher.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_lpm_searcher.sv
// router_lpm_searcher: longest-prefix-match route table with a 3-stage tagged lookup pipeline.
// Runtime table writes are taken only when S1 and S2 are empty. Writes win over lookups.
// Optional hit/miss statistics are compiled in when ROUTER_LPM_STATS_EN is defined.
module router_lpm_searcher #(
    parameter  int unsigned MAX_ENTRIES = 64,
    parameter  int unsigned TAG_WIDTH   = 8,
    parameter  int unsigned ENTRY_WIDTH = 256,
    localparam int unsigned IDX_W       = $clog2(MAX_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef ROUTER_LPM_STATS_EN
    input  logic                   stats_clr,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count,
`endif
    input  logic                   cfg_wr,
    output logic                   cfg_ready,
    input  logic [IDX_W-1:0]       cfg_addr,
    input  logic [ENTRY_WIDTH-1:0] cfg_data,
    input  logic                   lookup_valid,
    output logic                   lookup_ready,
    input  logic [31:0]            lookup_dst_ip,
    input  logic [TAG_WIDTH-1:0]   lookup_tag,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_found,
    output logic [IDX_W-1:0]       resp_index,
    output logic [5:0]             resp_prefix_len,
    output logic [TAG_WIDTH-1:0]   resp_tag,
    output logic [15:0]            resp_out_port,
    output logic [15:0]            resp_out_qp,
    output logic [15:0]            resp_next_hop_port,
    output logic [15:0]            resp_next_hop_qp,
    output logic [31:0]            resp_next_hop_ip,
    output logic [47:0]            resp_next_hop_mac,
    output logic                   resp_is_direct_host,
    output logic                   resp_is_broadcast
);

    // Forwarding payload kept per entry: entry bits [207:64].
    localparam int unsigned PAY_W = 144;

    // Clamp a stored prefix length to the usable range 0..32.
    function automatic logic [5:0] eff_len(input logic [5:0] len);
        eff_len = (len >= 6'd32) ? 6'd32 : len;
    endfunction

    // Network mask with the top eff_len bits set; length 0 is the default route.
    function automatic logic [31:0] len_mask(input logic [5:0] len);
        logic [5:0] e;
        e = eff_len(len);
        if (e == 6'd0) begin
            len_mask = 32'd0;
        end else begin
            len_mask = ~32'd0 << (6'd32 - e);
        end
    endfunction

    // ---------------------------------------------------------------- table
    logic [MAX_ENTRIES-1:0] valid_q;
    logic [31:0]            key_q  [MAX_ENTRIES];
    logic [5:0]             len_q  [MAX_ENTRIES];
    logic                   dh_q   [MAX_ENTRIES];
    logic                   bc_q   [MAX_ENTRIES];
    logic [PAY_W-1:0]       pay_q  [MAX_ENTRIES];

    // ---------------------------------------------------------------- pipeline state
    logic                   v_s1_q;
    logic [MAX_ENTRIES-1:0] match_s1_q;
    logic [5:0]             len_s1_q   [MAX_ENTRIES];
    logic [TAG_WIDTH-1:0]   tag_s1_q;

    logic                   v_s2_q;
    logic                   found_s2_q;
    logic [IDX_W-1:0]       idx_s2_q;
    logic [5:0]             len_s2_q;
    logic [TAG_WIDTH-1:0]   tag_s2_q;

    logic                   resp_valid_q;
    logic                   resp_found_q;
    logic [IDX_W-1:0]       resp_index_q;
    logic [5:0]             resp_len_q;
    logic [TAG_WIDTH-1:0]   resp_tag_q;
    logic [PAY_W-1:0]       resp_pay_q;
    logic                   resp_dh_q;
    logic                   resp_bc_q;

    // ---------------------------------------------------------------- control
    logic stall_c;
    logic cfg_fire_c;
    logic lookup_fire_c;

    // Handshake decode: a held response freezes the pipe, writes wait for S1/S2 to drain.
    always_comb begin
        stall_c       = resp_valid_q && !resp_ready;
        cfg_ready     = !v_s1_q && !v_s2_q;
        cfg_fire_c    = cfg_wr && cfg_ready;
        lookup_ready  = !stall_c && !cfg_wr;
        lookup_fire_c = lookup_valid && lookup_ready;
    end

    // Entry valid bits are the only table state cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (cfg_fire_c) begin
            valid_q[cfg_addr] <= cfg_data[32];
        end
    end

    // Entry key, length and payload are written together with the valid bit.
    always_ff @(posedge clk) begin
        if (cfg_fire_c) begin
            key_q[cfg_addr] <= cfg_data[31:0];
            len_q[cfg_addr] <= cfg_data[61:56];
            dh_q[cfg_addr]  <= cfg_data[40];
            bc_q[cfg_addr]  <= cfg_data[48];
            pay_q[cfg_addr] <= cfg_data[207:64];
        end
    end

    // Bits of the entry image that carry no meaning for forwarding.
    logic unused_cfg_bits;
    if (ENTRY_WIDTH > 208) begin : g_hi_bits
        assign unused_cfg_bits = ^{cfg_data[ENTRY_WIDTH-1:208], cfg_data[63:62],
                                   cfg_data[55:49], cfg_data[47:41], cfg_data[39:33]};
    end else begin : g_no_hi_bits
        assign unused_cfg_bits = ^{cfg_data[63:62], cfg_data[55:49],
                                   cfg_data[47:41], cfg_data[39:33]};
    end

    // ---------------------------------------------------------------- stage 1
    logic [MAX_ENTRIES-1:0] match_c;
    logic [5:0]             eff_len_c [MAX_ENTRIES];

    // Parallel compare of the destination against every entry.
    always_comb begin
        match_c = '0;
        for (int unsigned g = 0; g < MAX_ENTRIES; g++) begin
            eff_len_c[IDX_W'(g)] = eff_len(len_q[IDX_W'(g)]);
            match_c[IDX_W'(g)]   = valid_q[IDX_W'(g)] &&
                (((key_q[IDX_W'(g)] ^ lookup_dst_ip) & len_mask(len_q[IDX_W'(g)])) == 32'd0);
        end
    end

    // S1 occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_s1_q <= 1'b0;
        end else if (!stall_c) begin
            v_s1_q <= lookup_fire_c;
        end
    end

    // S1 payload: match vector, effective lengths and tag.
    always_ff @(posedge clk) begin
        if (!stall_c && lookup_fire_c) begin
            match_s1_q <= match_c;
            len_s1_q   <= eff_len_c;
            tag_s1_q   <= lookup_tag;
        end
    end

    // ---------------------------------------------------------------- stage 2
    logic             best_found_c;
    logic [IDX_W-1:0] best_idx_c;
    logic [5:0]       best_len_c;

    // Longest matching prefix wins; strict compare keeps the lowest index on ties.
    always_comb begin
        best_found_c = 1'b0;
        best_idx_c   = '0;
        best_len_c   = 6'd0;
        for (int unsigned g = 0; g < MAX_ENTRIES; g++) begin
            if (match_s1_q[IDX_W'(g)] &&
                (!best_found_c || (len_s1_q[IDX_W'(g)] > best_len_c))) begin
                best_found_c = 1'b1;
                best_idx_c   = IDX_W'(g);
                best_len_c   = len_s1_q[IDX_W'(g)];
            end
        end
    end

    // S2 occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_s2_q <= 1'b0;
        end else if (!stall_c) begin
            v_s2_q <= v_s1_q;
        end
    end

    // S2 payload: winner index, length and tag.
    always_ff @(posedge clk) begin
        if (!stall_c && v_s1_q) begin
            found_s2_q <= best_found_c;
            idx_s2_q   <= best_idx_c;
            len_s2_q   <= best_len_c;
            tag_s2_q   <= tag_s1_q;
        end
    end

    // ---------------------------------------------------------------- stage 3
    logic [PAY_W-1:0] rd_pay_c;
    logic             rd_dh_c;
    logic             rd_bc_c;

    // Entry read for the winner; a miss reads as all zero.
    always_comb begin
        rd_pay_c = '0;
        rd_dh_c  = 1'b0;
        rd_bc_c  = 1'b0;
        if (found_s2_q) begin
            rd_pay_c = pay_q[idx_s2_q];
            rd_dh_c  = dh_q[idx_s2_q];
            rd_bc_c  = bc_q[idx_s2_q];
        end
    end

    // Response register: loads from S2 when the pipe moves, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            resp_found_q <= 1'b0;
            resp_index_q <= '0;
            resp_len_q   <= 6'd0;
            resp_tag_q   <= '0;
            resp_pay_q   <= '0;
            resp_dh_q    <= 1'b0;
            resp_bc_q    <= 1'b0;
        end else if (!stall_c) begin
            resp_valid_q <= v_s2_q;
            if (v_s2_q) begin
                resp_found_q <= found_s2_q;
                resp_index_q <= found_s2_q ? idx_s2_q : '0;
                resp_len_q   <= found_s2_q ? len_s2_q : 6'd0;
                resp_tag_q   <= tag_s2_q;
                resp_pay_q   <= rd_pay_c;
                resp_dh_q    <= rd_dh_c;
                resp_bc_q    <= rd_bc_c;
            end
        end
    end

    // Field decode of the held payload (entry bits minus 64).
    always_comb begin
        resp_valid          = resp_valid_q;
        resp_found          = resp_found_q;
        resp_index          = resp_index_q;
        resp_prefix_len     = resp_len_q;
        resp_tag            = resp_tag_q;
        resp_out_port       = resp_pay_q[15:0];
        resp_out_qp         = resp_pay_q[31:16];
        resp_next_hop_ip    = resp_pay_q[63:32];
        resp_next_hop_port  = resp_pay_q[79:64];
        resp_next_hop_qp    = resp_pay_q[95:80];
        resp_next_hop_mac   = resp_pay_q[143:96];
        resp_is_direct_host = resp_dh_q;
        resp_is_broadcast   = resp_bc_q;
    end

`ifdef ROUTER_LPM_STATS_EN
    // ---------------------------------------------------------------- statistics
    logic        resp_fire_c;
    logic [31:0] hit_q;
    logic [31:0] miss_q;

    // Response handshake strobe.
    always_comb begin
        resp_fire_c = resp_valid_q && resp_ready;
    end

    // Saturating hit/miss counters; clear wins over a same-cycle count.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            hit_q  <= 32'd0;
            miss_q <= 32'd0;
        end else if (resp_fire_c) begin
            if (resp_found_q) begin
                if (hit_q != 32'hFFFF_FFFF) begin
                    hit_q <= hit_q + 32'd1;
                end
            end else begin
                if (miss_q != 32'hFFFF_FFFF) begin
                    miss_q <= miss_q + 32'd1;
                end
            end
        end
    end

    // Counter outputs.
    always_comb begin
        hit_count  = hit_q;
        miss_count = miss_q;
    end
`endif

endmodule

// File: tb/tb_router_lpm_searcher.sv
// Directed self-checking bench for router_lpm_searcher.
module tb_router_lpm_searcher;

    localparam int unsigned MAX_ENTRIES = 64;
    localparam int unsigned TAG_WIDTH   = 8;
    localparam int unsigned ENTRY_WIDTH = 256;
    localparam int unsigned IDX_W       = 6;

    typedef struct packed {
        logic        found;
        logic [5:0]  idx;
        logic [5:0]  len;
        logic [7:0]  tag;
        logic [15:0] oport;
        logic [15:0] oqp;
        logic [31:0] nhip;
        logic [15:0] nhport;
        logic [15:0] nhqp;
        logic [47:0] mac;
        logic        dh;
        logic        bc;
    } resp_t;

    typedef struct {
        logic [31:0] ip;
        logic [7:0]  tag;
        bit          found;
        int          idx;
        int          len;
        logic [15:0] port;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_wr;
    logic                   cfg_ready;
    logic [IDX_W-1:0]       cfg_addr;
    logic [ENTRY_WIDTH-1:0] cfg_data;
    logic                   lookup_valid;
    logic                   lookup_ready;
    logic [31:0]            lookup_dst_ip;
    logic [TAG_WIDTH-1:0]   lookup_tag;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   resp_found;
    logic [IDX_W-1:0]       resp_index;
    logic [5:0]             resp_prefix_len;
    logic [TAG_WIDTH-1:0]   resp_tag;
    logic [15:0]            resp_out_port, resp_out_qp, resp_next_hop_port, resp_next_hop_qp;
    logic [31:0]            resp_next_hop_ip;
    logic [47:0]            resp_next_hop_mac;
    logic                   resp_is_direct_host, resp_is_broadcast;
`ifdef ROUTER_LPM_STATS_EN
    logic                   stats_clr;
    logic [31:0]            hit_count, miss_count;
`endif

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    router_lpm_searcher #(
        .MAX_ENTRIES (MAX_ENTRIES),
        .TAG_WIDTH   (TAG_WIDTH),
        .ENTRY_WIDTH (ENTRY_WIDTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
`ifdef ROUTER_LPM_STATS_EN
        .stats_clr           (stats_clr),
        .hit_count           (hit_count),
        .miss_count          (miss_count),
`endif
        .cfg_wr              (cfg_wr),
        .cfg_ready           (cfg_ready),
        .cfg_addr            (cfg_addr),
        .cfg_data            (cfg_data),
        .lookup_valid        (lookup_valid),
        .lookup_ready        (lookup_ready),
        .lookup_dst_ip       (lookup_dst_ip),
        .lookup_tag          (lookup_tag),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_found          (resp_found),
        .resp_index          (resp_index),
        .resp_prefix_len     (resp_prefix_len),
        .resp_tag            (resp_tag),
        .resp_out_port       (resp_out_port),
        .resp_out_qp         (resp_out_qp),
        .resp_next_hop_port  (resp_next_hop_port),
        .resp_next_hop_qp    (resp_next_hop_qp),
        .resp_next_hop_ip    (resp_next_hop_ip),
        .resp_next_hop_mac   (resp_next_hop_mac),
        .resp_is_direct_host (resp_is_direct_host),
        .resp_is_broadcast   (resp_is_broadcast)
    );

    function automatic logic [31:0] ip4(input int a, input int b, input int c, input int d);
        ip4 = {8'(a), 8'(b), 8'(c), 8'(d)};
    endfunction

    // Entry image; all forwarding fields are derived from the out port number.
    function automatic logic [ENTRY_WIDTH-1:0] mk_entry(input logic [31:0] ip, input int len,
                                                        input bit vld, input logic [15:0] p);
        logic [ENTRY_WIDTH-1:0] e;
        e = '0;
        e[255:208] = 48'hDEAD_BEEF_CAFE;
        e[63:62]   = 2'b11;
        e[31:0]    = ip;
        e[32]      = vld;
        e[40]      = p[0];
        e[48]      = p[1];
        e[61:56]   = 6'(len);
        e[79:64]   = p;
        e[95:80]   = p + 16'd100;
        e[127:96]  = 32'hC0A8_0000 | {16'd0, p};
        e[143:128] = p + 16'd200;
        e[159:144] = p + 16'd300;
        e[207:160] = 48'h0200_0000_0000 | {32'd0, p};
        return e;
    endfunction

    function automatic resp_t exp_resp(input bit f, input int idx, input int len,
                                       input logic [7:0] tag, input logic [15:0] p);
        resp_t r;
        r = '0;
        r.tag = tag;
        if (f) begin
            r.found  = 1'b1;
            r.idx    = 6'(idx);
            r.len    = 6'(len);
            r.oport  = p;
            r.oqp    = p + 16'd100;
            r.nhip   = 32'hC0A8_0000 | {16'd0, p};
            r.nhport = p + 16'd200;
            r.nhqp   = p + 16'd300;
            r.mac    = 48'h0200_0000_0000 | {32'd0, p};
            r.dh     = p[0];
            r.bc     = p[1];
        end
        return r;
    endfunction

    function automatic resp_t get_resp();
        resp_t r;
        r.found  = resp_found;
        r.idx    = resp_index;
        r.len    = resp_prefix_len;
        r.tag    = resp_tag;
        r.oport  = resp_out_port;
        r.oqp    = resp_out_qp;
        r.nhip   = resp_next_hop_ip;
        r.nhport = resp_next_hop_port;
        r.nhqp   = resp_next_hop_qp;
        r.mac    = resp_next_hop_mac;
        r.dh     = resp_is_direct_host;
        r.bc     = resp_is_broadcast;
        return r;
    endfunction

    function automatic resp_t vec_exp(input vec_t v);
        return exp_resp(v.found, v.idx, v.len, v.tag, v.port);
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input logic [ENTRY_WIDTH-1:0] data);
        int n;
        @(negedge clk);
        cfg_wr   = 1'b1;
        cfg_addr = IDX_W'(addr);
        cfg_data = data;
        n = 0;
        while (!cfg_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            nchk++;
            nerr++;
            $display("FAIL cfg_write_timeout: cfg_ready stayed 0 for entry %0d", addr);
        end
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    // Single lookup; returns with the response visible (handshake at the next edge).
    task automatic lookup_one(input logic [31:0] ip, input logic [7:0] tag,
                              output int lat, output resp_t r);
        int n;
        @(negedge clk);
        resp_ready    = 1'b1;
        lookup_valid  = 1'b1;
        lookup_dst_ip = ip;
        lookup_tag    = tag;
        n = 0;
        while (!lookup_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        r = get_resp();
    endtask

    vec_t  vecs [8];
    resp_t r, prev;
    int    lat;

    initial begin
        rst = 1'b1;
        cfg_wr = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        lookup_valid = 1'b0;
        lookup_dst_ip = '0;
        lookup_tag = '0;
        resp_ready = 1'b1;
`ifdef ROUTER_LPM_STATS_EN
        stats_clr = 1'b0;
`endif
        vecs[0] = '{ip4(10,1,2,3),      8'h5A, 1'b1, 7, 16, 16'd2};
        vecs[1] = '{ip4(10,200,0,1),    8'h11, 1'b1, 3,  8, 16'd1};
        vecs[2] = '{ip4(11,0,0,1),      8'h22, 1'b1, 0,  0, 16'd9};
        vecs[3] = '{ip4(192,168,1,77),  8'h33, 1'b1, 2, 24, 16'd20};
        vecs[4] = '{ip4(172,16,5,5),    8'h44, 1'b1, 9, 32, 16'd33};
        vecs[5] = '{ip4(172,16,5,6),    8'h55, 1'b1, 0,  0, 16'd9};
        vecs[6] = '{ip4(10,1,2,200),    8'h66, 1'b1, 7, 16, 16'd2};
        vecs[7] = '{ip4(192,168,2,1),   8'h77, 1'b1, 0,  0, 16'd9};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_handshake", {resp_valid, lookup_ready, cfg_ready}, 3'b011);
        chk("reset_resp", get_resp(), '0);
`ifdef ROUTER_LPM_STATS_EN
        chk("reset_stats", {hit_count, miss_count}, 64'd0);
`endif

        // Two overlapping prefixes: the longer one wins.
        cfg_write(3, mk_entry(ip4(10,0,0,0), 8, 1'b1, 16'd1));
        cfg_write(7, mk_entry(ip4(10,1,0,0), 16, 1'b1, 16'd2));
        lookup_one(ip4(10,1,2,3), 8'h5A, lat, r);
        chk("first_latency", 32'(lat), 32'd3);
        chk("first_lpm", r, exp_resp(1'b1, 7, 16, 8'h5A, 16'd2));
        lookup_one(ip4(11,0,0,1), 8'h22, lat, r);
        chk("miss_fields", r, exp_resp(1'b0, 0, 0, 8'h22, 16'd0));

        // Default route, tie pair, oversized length, invalid entry.
        cfg_write(0,  mk_entry(ip4(0,0,0,0), 0, 1'b1, 16'd9));
        cfg_write(2,  mk_entry(ip4(192,168,1,0), 24, 1'b1, 16'd20));
        cfg_write(5,  mk_entry(ip4(192,168,1,0), 24, 1'b1, 16'd50));
        cfg_write(9,  mk_entry(ip4(172,16,5,5), 40, 1'b1, 16'd33));
        cfg_write(12, mk_entry(ip4(10,1,2,0), 24, 1'b0, 16'd44));

        for (int i = 0; i < 8; i++) begin
            lookup_one(vecs[i].ip, vecs[i].tag, lat, r);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("vec%0d_resp", i), r, vec_exp(vecs[i]));
        end

        // Back-to-back stream with resp_ready low for 4 cycles.
        begin
            int  sent, got, cyc;
            bit  prev_stall;
            sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev = '0;
            while ((sent < 6 || got < 6) && cyc < 100) begin
                @(negedge clk);
                resp_ready   = !(cyc >= 3 && cyc < 7);
                lookup_valid = (sent < 6);
                if (sent < 6) begin
                    lookup_dst_ip = vecs[sent].ip;
                    lookup_tag    = vecs[sent].tag;
                end
                #1;
                if (resp_valid && !resp_ready) begin
                    chk("stall_lookup_ready", 1'(lookup_ready), 1'b0);
                    if (prev_stall) chk("stall_hold", get_resp(), prev);
                    prev = get_resp();
                    prev_stall = 1'b1;
                end else begin
                    prev_stall = 1'b0;
                end
                if (resp_valid && resp_ready) begin
                    chk($sformatf("stream%0d", got), get_resp(), vec_exp(vecs[got]));
                    got++;
                end
                if (lookup_valid && lookup_ready) sent++;
                cyc++;
            end
            lookup_valid = 1'b0;
            resp_ready   = 1'b1;
            chk("stream_count", 32'(got), 32'd6);
        end

        // Write behind three in-flight lookups; the write waits for the drain.
        begin
            int  sent, got, cyc;
            bit  wdone;
            resp_t exps [4];
            exps[0] = exp_resp(1'b1, 7, 16, 8'hA0, 16'd2);
            exps[1] = exp_resp(1'b1, 7, 16, 8'hA1, 16'd2);
            exps[2] = exp_resp(1'b1, 7, 16, 8'hA2, 16'd2);
            exps[3] = exp_resp(1'b1, 3,  8, 8'hA3, 16'd1);
            sent = 0; got = 0; cyc = 0; wdone = 1'b0;
            while ((got < 4 || !wdone) && cyc < 60) begin
                @(negedge clk);
                resp_ready    = 1'b1;
                lookup_valid  = (sent < 4);
                lookup_dst_ip = ip4(10,1,2,3);
                lookup_tag    = 8'(8'hA0 + sent);
                cfg_wr        = (sent == 3) && !wdone;
                cfg_addr      = IDX_W'(7);
                cfg_data      = mk_entry(ip4(10,1,0,0), 16, 1'b0, 16'd2);
                #1;
                if (cfg_wr) begin
                    chk($sformatf("cfg_ready_cyc%0d", cyc), 1'(cfg_ready), 1'(cyc >= 5));
                    chk($sformatf("wr_prio_cyc%0d", cyc), 1'(lookup_ready), 1'b0);
                    if (cfg_ready) wdone = 1'b1;
                end
                if (resp_valid && resp_ready) begin
                    if (got < 4) chk($sformatf("drain%0d", got), get_resp(), exps[got]);
                    got++;
                end
                if (lookup_valid && lookup_ready) sent++;
                cyc++;
            end
            cfg_wr = 1'b0;
            lookup_valid = 1'b0;
            chk("drain_count", {31'(got), wdone}, {31'd4, 1'b1});
        end

        // Reset with a lookup in flight: nothing emerges and the table is empty.
        @(negedge clk);
        lookup_valid  = 1'b1;
        lookup_dst_ip = ip4(10,1,2,3);
        lookup_tag    = 8'hEE;
        @(negedge clk);
        lookup_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            repeat (4) begin
                @(negedge clk);
                seen = seen | resp_valid;
            end
            chk("reset_flush", 1'(seen), 1'b0);
        end
        chk("reset_flush_resp", get_resp(), '0);
        lookup_one(ip4(10,1,2,3), 8'h99, lat, r);
        chk("post_reset_miss", r, exp_resp(1'b0, 0, 0, 8'h99, 16'd0));

`ifdef ROUTER_LPM_STATS_EN
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        cfg_write(3, mk_entry(ip4(10,0,0,0), 8, 1'b1, 16'd1));
        for (int i = 0; i < 5; i++) lookup_one(ip4(10, i, 0, 1), 8'(i), lat, r);
        for (int i = 0; i < 2; i++) lookup_one(ip4(11, i, 0, 1), 8'(i), lat, r);
        @(negedge clk);
        chk("stats_counts", {hit_count, miss_count}, {32'd5, 32'd2});
        lookup_one(ip4(10,9,9,9), 8'h01, lat, r);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        chk("stats_clr_wins", {hit_count, miss_count}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
